// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions: format coding, legal ranges,
// and the pipeline stage bundles used by the immediate encoder.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_fmt_e;

    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4095;
    localparam int IMM_J_MIN  = -1048576;
    localparam int IMM_J_MAX  = 1048575;

    typedef struct packed {
        imm_fmt_e    fmt;
        logic [20:0] imm;
        logic [31:7] base;
        logic        range_err;
        logic        align_err;
    } s1_t;

    typedef struct packed {
        logic [31:7] bits;
        logic        range_err;
        logic        align_err;
    } s2_t;

    function automatic logic signed [31:0] fmt_min(imm_fmt_e f);
        logic signed [31:0] r;
        r = IMM_IS_MIN;
        unique case (f)
            IMM_I, IMM_S: r = IMM_IS_MIN;
            IMM_B:        r = IMM_B_MIN;
            IMM_J:        r = IMM_J_MIN;
        endcase
        return r;
    endfunction

    function automatic logic signed [31:0] fmt_max(imm_fmt_e f);
        logic signed [31:0] r;
        r = IMM_IS_MAX;
        unique case (f)
            IMM_I, IMM_S: r = IMM_IS_MAX;
            IMM_B:        r = IMM_B_MAX;
            IMM_J:        r = IMM_J_MAX;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational scatter of an immediate into instruction bits [31:7],
// merging the non-immediate fields from base.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  imm_fmt_e    fmt,
    input  logic [20:0] imm,
    input  logic [31:7] base,
    output logic [31:7] bits
);

    always_comb begin
        bits = base;
        unique case (fmt)
            IMM_I: bits = {imm[11:0], base[19:7]};
            IMM_S: bits = {imm[11:5], base[24:12], imm[4:0]};
            IMM_B: bits = {imm[12], imm[10:5], base[24:12],
                           imm[4:1], imm[11]};
            IMM_J: bits = {imm[20], imm[10:1], imm[11],
                           imm[19:12], base[11:7]};
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 captures request and error flags,
// S2 holds the packed instruction bits presented to the consumer.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  imm_fmt,
    input  logic [31:0] imm_val,
    input  logic [31:7] base_bits,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:7] out_bits,
    output logic        out_range_err,
    output logic        out_align_err,
    output logic [7:0]  err_count,
    input  logic        err_clr
);

    logic               s1_valid_q, s1_valid_d;
    logic               s2_valid_q, s2_valid_d;
    s1_t                s1_q, s1_d;
    s2_t                s2_q, s2_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               s2_adv, accept;
    logic               range_err, align_err;
    logic signed [31:0] imm_s;
    imm_fmt_e           fmt_in;
    logic [31:7]        packed_bits;

    assign fmt_in   = imm_fmt_e'(imm_fmt);
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        imm_s     = $signed(imm_val);
        range_err = (imm_s < fmt_min(fmt_in)) ||
                    (imm_s > fmt_max(fmt_in));
        align_err = imm_val[0] &&
                    (fmt_in == IMM_B || fmt_in == IMM_J);
    end

    imm_pack u_pack (
        .fmt  (s1_q.fmt),
        .imm  (s1_q.imm),
        .base (s1_q.base),
        .bits (packed_bits)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        err_cnt_d  = err_cnt_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_d.fmt       = fmt_in;
            s1_d.imm       = imm_val[20:0];
            s1_d.base      = base_bits;
            s1_d.range_err = range_err;
            s1_d.align_err = align_err;
        end
        // S2 keeps stale data when emptied; only out_valid matters then
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.bits      = packed_bits;
                s2_d.range_err = s1_q.range_err;
                s2_d.align_err = s1_q.align_err;
            end
        end
        if (err_clr) begin
            err_cnt_d = 8'd0;
        end else if (accept && (range_err || align_err) &&
                     err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            err_cnt_q  <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_bits      = s2_q.bits;
    assign out_range_err = s2_q.range_err;
    assign out_align_err = s2_q.align_err;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized bench for imm_encoder with a scoreboard
// model and an extend-style decoder for loopback of legal immediates.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  imm_fmt = 2'b00;
    logic [31:0] imm_val = '0;
    logic [31:7] base_bits = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:7] out_bits;
    logic        out_range_err;
    logic        out_align_err;
    logic [7:0]  err_count;
    logic        err_clr = 1'b0;

    imm_encoder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .imm_fmt       (imm_fmt),
        .imm_val       (imm_val),
        .base_bits     (base_bits),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bits      (out_bits),
        .out_range_err (out_range_err),
        .out_align_err (out_align_err),
        .err_count     (err_count),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:7] bits;
        logic        rerr;
        logic        aerr;
        logic [1:0]  fmt;
        logic [31:0] imm;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          model_cnt = 0;
    int          loopbacks = 0;
    logic        hold_v = 1'b0;
    logic [31:7] hold_bits;
    logic [31:7] last_bits;
    logic        last_rerr, last_aerr;
    int          last_lat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fmt_bits(input logic [1:0] f);
        case (f)
            2'd0, 2'd1: return 12;
            2'd2:       return 13;
            default:    return 21;
        endcase
    endfunction

    // Reference encoding: place each immediate bit at its field position
    function automatic logic [31:7] enc(input logic [1:0] f,
                                        input logic [31:0] im,
                                        input logic [31:7] b);
        logic [31:0] w;
        w = {b, 7'd0};
        case (f)
            2'd0: for (int k = 0; k < 12; k++) w[20+k] = im[k];
            2'd1: begin
                for (int k = 0; k < 5; k++)  w[7+k]  = im[k];
                for (int k = 5; k < 12; k++) w[20+k] = im[k];
            end
            2'd2: begin
                w[7]  = im[11];
                for (int k = 1; k < 5; k++)  w[7+k]  = im[k];
                for (int k = 5; k < 11; k++) w[20+k] = im[k];
                w[31] = im[12];
            end
            default: begin
                for (int k = 1; k < 11; k++)  w[20+k] = im[k];
                w[20] = im[11];
                for (int k = 12; k < 20; k++) w[k] = im[k];
                w[31] = im[20];
            end
        endcase
        return w[31:7];
    endfunction

    function automatic logic [31:0] dec(input logic [1:0] f,
                                        input logic [31:7] ob);
        logic [31:0] w;
        w = {ob, 7'd0};
        case (f)
            2'd0: return {{20{w[31]}}, w[31:20]};
            2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2: return {{19{w[31]}}, w[31], w[7], w[30:25],
                          w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20],
                             w[30:21], 1'b0};
        endcase
    endfunction

    task automatic step(input logic v, input logic [1:0] f,
                        input logic [31:0] im, input logic [31:7] b,
                        input logic ordy, input logic clr,
                        output logic acc, output logic rdy);
        exp_t e;
        int   n;
        logic exp_ov;
        @(negedge clk);
        in_valid  = v;
        imm_fmt   = f;
        imm_val   = im;
        base_bits = b;
        out_ready = ordy;
        err_clr   = clr;
        #1;
        if (hold_v) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_bits", {7'd0, out_bits}, {7'd0, hold_bits});
        end
        exp_ov = (q.size() > 0) && (cyc - q[0].cyc >= 2);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("in_ready", {31'd0, in_ready},
            {31'd0, (q.size() < 2) || ordy});
        chk("err_count", {24'd0, err_count}, model_cnt);
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("bits", {7'd0, out_bits}, {7'd0, e.bits});
            chk("range_err", {31'd0, out_range_err}, {31'd0, e.rerr});
            chk("align_err", {31'd0, out_align_err}, {31'd0, e.aerr});
            if (!e.rerr && !e.aerr) begin
                chk("loopback", dec(e.fmt, out_bits), e.imm);
                loopbacks++;
            end
            last_bits = out_bits;
            last_rerr = out_range_err;
            last_aerr = out_align_err;
            last_lat  = cyc - e.cyc;
        end
        hold_v    = out_valid && !out_ready;
        hold_bits = out_bits;
        acc = in_valid && in_ready;
        rdy = in_ready;
        if (acc) begin
            n      = fmt_bits(f);
            e.fmt  = f;
            e.imm  = im;
            e.cyc  = cyc;
            e.bits = enc(f, im, b);
            e.rerr = ($signed(im) < -(1 <<< (n - 1))) ||
                     ($signed(im) > (1 <<< (n - 1)) - 1);
            e.aerr = f[1] && im[0];
            q.push_back(e);
        end
        if (clr) model_cnt = 0;
        else if (acc && (e.rerr || e.aerr) && model_cnt < 255)
            model_cnt++;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_bits", {7'd0, out_bits}, 32'd0);
        chk("rst_flags", {30'd0, out_range_err, out_align_err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        q.delete();
        model_cnt = 0;
        hold_v    = 1'b0;
        in_valid  = 1'b0;
        err_clr   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run1(input logic [1:0] f, input logic [31:0] im);
        logic a, r;
        step(1'b1, f, im, '0, 1'b1, 1'b0, a, r);
        step(1'b0, 2'd0, 32'd0, '0, 1'b1, 1'b0, a, r);
        step(1'b0, 2'd0, 32'd0, '0, 1'b1, 1'b0, a, r);
    endtask

    initial begin
        logic        a, r, blocked, v, ordy;
        logic [1:0]  f;
        logic [31:0] im;
        int          idx, n;

        #2;
        do_reset();

        run1(2'd0, 32'd14);
        chk("req033_bits", {7'd0, last_bits},
            {7'd0, 25'b000000001110_0000000000000});
        chk("req033_lat", last_lat, 2);
        chk("req033_flags", {30'd0, last_rerr, last_aerr}, 32'd0);
        run1(2'd0, -32'sd10);
        chk("req034_neg", {20'd0, last_bits[31:20]},
            {20'd0, 12'b111111110110});
        run1(2'd0, 32'd2048);
        chk("req034_range", {31'd0, last_rerr}, 32'd1);
        chk("req034_cnt", {24'd0, err_count}, 32'd1);
        run1(2'd1, 32'd72);
        chk("req035_s", {7'd0, last_bits},
            {7'd0, 25'b0000010_00000_00000_000_01000});
        run1(2'd2, 32'd48);
        chk("req035_b", {7'd0, last_bits},
            {7'd0, 25'b0_000001_00000_00000_000_1000_0});
        run1(2'd3, 32'd28);
        chk("req036_j", {7'd0, last_bits},
            {7'd0, 25'b0_0000001110_0_00000000_00000});
        run1(2'd2, 32'd49);
        chk("req036_align", {31'd0, last_aerr}, 32'd1);
        run1(2'd1, 32'd2047);
        chk("s_max_ok", {31'd0, last_rerr}, 32'd0);
        run1(2'd2, -32'sd4098);
        chk("b_below_min", {31'd0, last_rerr}, 32'd1);
        run1(2'd3, 32'd1048576);
        chk("j_above_max", {31'd0, last_rerr}, 32'd1);

        // Four back-to-back requests with a 3-cycle consumer stall
        blocked = 1'b0;
        idx = 0;
        for (int k = 0; k < 30 && idx < 4; k++) begin
            ordy = !(k >= 1 && k <= 3);
            step(1'b1, 2'(idx), 32'(idx * 6 + 2), 25'(idx * 977),
                 ordy, 1'b0, a, r);
            if (!r) blocked = 1'b1;
            if (a) idx++;
        end
        chk("stall_all_sent", idx, 4);
        chk("stall_in_ready_drop", {31'd0, blocked}, 32'd1);
        for (int k = 0; k < 10; k++)
            step(1'b0, 2'd0, 32'd0, '0, 1'b1, 1'b0, a, r);
        chk("stall_drained", q.size(), 0);

        // Error counter saturation and clear priority
        for (int k = 0; k < 300; k++)
            step(1'b1, 2'd0, 32'd4096, '0, 1'b1, 1'b0, a, r);
        step(1'b1, 2'd3, 32'd1, '0, 1'b1, 1'b0, a, r);
        chk("err_sat", {24'd0, err_count}, 32'd255);
        step(1'b1, 2'd2, 32'd3, '0, 1'b1, 1'b1, a, r);
        step(1'b0, 2'd0, 32'd0, '0, 1'b1, 1'b0, a, r);
        chk("err_clr_wins", {24'd0, err_count}, 32'd0);

        for (int k = 0; k < 1800; k++) begin
            v    = ($urandom_range(0, 9) < 8);
            ordy = ($urandom_range(0, 3) != 0);
            f    = 2'($urandom_range(0, 3));
            n    = fmt_bits(f);
            if ($urandom_range(0, 9) == 0) begin
                im = $urandom;
                if ($urandom_range(0, 1) == 0) im = im >>> 10;
            end else begin
                im = 32'(-(1 <<< (n - 1)) +
                         int'($urandom_range(0, (1 << n) - 1)));
                if (f[1] && $urandom_range(0, 15) != 0) im[0] = 1'b0;
            end
            step(v, f, im, 25'($urandom), ordy,
                 ($urandom_range(0, 63) == 0), a, r);
            if (k == 900) do_reset();
        end
        for (int k = 0; k < 10; k++)
            step(1'b0, 2'd0, 32'd0, '0, 1'b1, 1'b0, a, r);
        chk("final_drained", q.size(), 0);
        chk("loopback_volume", {31'd0, loopbacks >= 1000}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
